// File: rtl/multiplicador_pkg.sv
// Shared constants for the multiplier operand path: demux select codes and
// the operand loader state encoding.
package multiplicador_pkg;

    localparam logic [1:0] OP_A      = 2'b00;
    localparam logic [1:0] OP_B      = 2'b01;
    localparam logic [1:0] OP_C      = 2'b10;
    localparam logic [1:0] OP_NENHUM = 2'b11;

    typedef enum logic [2:0] {
        S_OCIOSO  = 3'd0,
        S_CARGA_A = 3'd1,
        S_CARGA_B = 3'd2,
        S_CARGA_C = 3'd3,
        S_CHEIO   = 3'd4
    } estado_t;

    // Demux select code that matches the register loaded in each state.
    function automatic logic [1:0] op_do_estado(input estado_t estado);
        case (estado)
            S_CARGA_A: op_do_estado = OP_A;
            S_CARGA_B: op_do_estado = OP_B;
            S_CARGA_C: op_do_estado = OP_C;
            default:   op_do_estado = OP_NENHUM;
        endcase
    endfunction

endpackage

// File: rtl/registrador_operando.sv
// Operand register with synchronous clear and load enable.
// Clear wins over load, so an aborted set never captures its last word.
module registrador_operando #(
    parameter int WIDTH = 10
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             limpar,
    input  logic             carregar,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Holds unless cleared or loaded.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            q <= '0;
        else if (limpar)
            q <= '0;
        else if (carregar)
            q <= d;
    end

endmodule

// File: rtl/sequenciador_operandos.sv
// Operand loader: captures A, B and C in order from the shared operand bus,
// drives the demux select to match, and holds the set until acknowledged.
//
// state     | meaning
// ----------+----------------------------------------------
// S_OCIOSO  | idle, no set being loaded, select none
// S_CARGA_A | waiting for word A, select A
// S_CARGA_B | waiting for word B, select B
// S_CARGA_C | waiting for word C, select C
// S_CHEIO   | set complete, held until consumir
module sequenciador_operandos
    import multiplicador_pkg::*;
#(
    parameter int WIDTH = 10
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             iniciar,
    input  logic             cancelar,
    input  logic [WIDTH-1:0] entrada,
    input  logic             entrada_valida,
    output logic             entrada_pronta,
    output logic [1:0]       op,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic             operandos_prontos,
    input  logic             consumir,
    output logic [7:0]       conjuntos
);

    estado_t estado, proximo;
    logic    transferencia;
    logic    abortar;
    logic    carga_a, carga_b, carga_c;

    // Moore outputs decoded from the registered state only.
    always_comb begin
        op                = op_do_estado(estado);
        entrada_pronta    = 1'b0;
        operandos_prontos = 1'b0;
        case (estado)
            S_CARGA_A, S_CARGA_B, S_CARGA_C: entrada_pronta    = 1'b1;
            S_CHEIO:                         operandos_prontos = 1'b1;
            default: ;
        endcase
    end

    assign abortar       = cancelar & entrada_pronta;
    assign transferencia = entrada_valida & entrada_pronta & ~abortar;
    assign carga_a       = transferencia & (estado == S_CARGA_A);
    assign carga_b       = transferencia & (estado == S_CARGA_B);
    assign carga_c       = transferencia & (estado == S_CARGA_C);

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            estado <= S_OCIOSO;
        else
            estado <= proximo;
    end

    // Next-state logic; cancel overrides any transfer in a load state.
    always_comb begin
        proximo = estado;
        case (estado)
            S_OCIOSO:  if (iniciar) proximo = S_CARGA_A;
            S_CARGA_A: if (abortar) proximo = S_OCIOSO;
                       else if (transferencia) proximo = S_CARGA_B;
            S_CARGA_B: if (abortar) proximo = S_OCIOSO;
                       else if (transferencia) proximo = S_CARGA_C;
            S_CARGA_C: if (abortar) proximo = S_OCIOSO;
                       else if (transferencia) proximo = S_CHEIO;
            S_CHEIO:   if (consumir) proximo = iniciar ? S_CARGA_A : S_OCIOSO;
            default:   proximo = S_OCIOSO;
        endcase
    end

    // Completed-set counter, wraps naturally at 8 bits.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            conjuntos <= '0;
        else if (carga_c)
            conjuntos <= conjuntos + 8'd1;
    end

    registrador_operando #(.WIDTH(WIDTH)) u_reg_a (
        .clock(clock), .reset_n(reset_n), .limpar(abortar),
        .carregar(carga_a), .d(entrada), .q(a)
    );

    registrador_operando #(.WIDTH(WIDTH)) u_reg_b (
        .clock(clock), .reset_n(reset_n), .limpar(abortar),
        .carregar(carga_b), .d(entrada), .q(b)
    );

    registrador_operando #(.WIDTH(WIDTH)) u_reg_c (
        .clock(clock), .reset_n(reset_n), .limpar(abortar),
        .carregar(carga_c), .d(entrada), .q(c)
    );

endmodule
